// File: rtl/muladd_load_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muladd_load_sequencer                                        |
// | Description : Fetches the Input vector and N_LAYER weight matrices from    |
// |               the staging SRAM, two 16-bit elements per read, and replays  |
// |               them on the MulAdd_top load port in array beat order with    |
// |               GAP idle cycles between phases. start/busy/done/abort.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muladd_load_sequencer #(
  parameter int N_LAYER = 8,
  parameter int GAP     = 24,
  parameter int AW      = 12
) (
  input  logic          clk_data,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_hi_o,
  output logic [AW-1:0] rd_addr_lo_o,
  input  logic [15:0]   rd_data_hi_i,
  input  logic [15:0]   rd_data_lo_i,
  output logic          load_en_o,
  output logic [31:0]   load_payload_o
);

  localparam int NW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L0    = 3'd1,
    S_GAP   = 3'd2,
    S_LN    = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      beat_q, beat_d;     // beat i, 1..8 while issuing
  logic [4:0]      burst_q, burst_d;   // burst k
  logic [NW-1:0]   layer_q, layer_d;   // layer n, 0 during L0
  logic [GW-1:0]   gap_q, gap_d;       // gap / flush cycle count
  logic            done_q, done_d;
  logic            v1_q, v1_d;         // read issued last cycle, data on bus now
  logic            v2_q, v2_d;         // payload register holds a fresh beat
  logic [31:0]     payload_q, payload_d;

  logic            w_abort;
  logic            w_rd_en;
  logic [3:0]      w_two_i, w_high, w_low, w_col_hi, w_col_lo;
  logic [AW-1:0]   w_row_hi, w_row_lo, w_half, w_layer_base;
  logic [AW-1:0]   w_addr_hi, w_addr_lo;

  assign w_abort = abort_i && (state_q != S_IDLE);
  assign w_rd_en = (state_q == S_L0) || (state_q == S_LN);

  // Next-state and counter update; abort overrides any transition.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    layer_d = layer_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_L0;
          beat_d  = 4'd1;
          burst_d = '0;
          layer_d = '0;
          gap_d   = '0;
        end
      end
      S_L0: begin
        if (beat_q == 4'd8) begin
          beat_d = 4'd1;
          if (burst_q == 5'd31) begin
            state_d = S_GAP;
            burst_d = '0;
            gap_d   = '0;
          end else begin
            burst_d = burst_q + 5'd1;
          end
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_LN;
          gap_d   = '0;
          layer_d = layer_q + NW'(1);
          beat_d  = 4'd1;
          burst_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_LN: begin
        if (beat_q == 4'd8) begin
          beat_d = 4'd1;
          if (burst_q == 5'd15) begin
            burst_d = '0;
            gap_d   = '0;
            if (layer_q == NW'(N_LAYER - 1)) begin
              state_d = S_FLUSH;
              beat_d  = '0;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            burst_d = burst_q + 5'd1;
          end
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_FLUSH: begin
        // Two cycles let the last beat drain through the read pipeline.
        if (gap_q == GW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          gap_d   = '0;
          layer_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_abort) begin
      state_d = S_IDLE;
      beat_d  = '0;
      burst_d = '0;
      layer_d = '0;
      gap_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Element address generation from (layer, burst, beat).
  always_comb begin
    w_two_i      = {beat_q[2:0], 1'b0};              // 2i mod 16
    w_high       = burst_q[3:0] + w_two_i - 4'd2;
    w_low        = burst_q[3:0] + w_two_i - 4'd1;
    w_col_hi     = ~w_high;                          // 15 - high
    w_col_lo     = ~w_low;
    w_row_hi     = AW'(17) - AW'({beat_q, 1'b0});
    w_row_lo     = AW'(16) - AW'({beat_q, 1'b0});
    w_half       = AW'(burst_q[4:1]);                // r or c in L0
    w_layer_base = (AW'(layer_q) + AW'(1)) << 8;     // 256 + 256*n
    w_addr_hi    = '0;
    w_addr_lo    = '0;
    if (state_q == S_L0) begin
      if (!burst_q[0]) begin
        w_addr_hi = (w_half << 4) + w_row_hi;
        w_addr_lo = (w_half << 4) + w_row_lo;
      end else begin
        w_addr_hi = w_layer_base + (w_row_hi << 4) + w_half;
        w_addr_lo = w_layer_base + (w_row_lo << 4) + w_half;
      end
    end else if (state_q == S_LN) begin
      w_addr_hi = w_layer_base + (w_row_hi << 4) + AW'(w_col_hi);
      w_addr_lo = w_layer_base + (w_row_lo << 4) + AW'(w_col_lo);
    end
  end

  // Read pipeline: strobe -> data return -> payload register.
  always_comb begin
    v1_d      = w_rd_en && !w_abort;
    v2_d      = v1_q && !w_abort;
    payload_d = (v1_q && !w_abort) ? {rd_data_hi_i, rd_data_lo_i} : payload_q;
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      burst_q   <= '0;
      layer_q   <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      layer_q   <= layer_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      payload_q <= payload_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign rd_en_o        = w_rd_en;
  assign rd_addr_hi_o   = w_addr_hi;
  assign rd_addr_lo_o   = w_addr_lo;
  assign load_en_o      = v2_q;
  assign load_payload_o = payload_q;

endmodule
`default_nettype wire

// File: tb/tb_muladd_load_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_muladd_load_sequencer                                     |
// | Description : Randomized self-checking bench; a schedule model built from  |
// |               the SRAM map and beat formulas predicts every output.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_muladd_load_sequencer;

  localparam int N_LAYER = 8;
  localparam int GAP     = 24;
  localparam int AW      = 12;
  localparam int T_MAX   = 1400;

  logic          clk_data = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, rd_en_o, load_en_o;
  logic [AW-1:0] rd_addr_hi_o, rd_addr_lo_o;
  logic [15:0]   rd_data_hi_i = 16'h0;
  logic [15:0]   rd_data_lo_i = 16'h0;
  logic [31:0]   load_payload_o;

  always #5 clk_data = ~clk_data;

  muladd_load_sequencer #(.N_LAYER(N_LAYER), .GAP(GAP), .AW(AW)) dut (
    .clk_data       (clk_data),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rd_en_o        (rd_en_o),
    .rd_addr_hi_o   (rd_addr_hi_o),
    .rd_addr_lo_o   (rd_addr_lo_o),
    .rd_data_hi_i   (rd_data_hi_i),
    .rd_data_lo_i   (rd_data_lo_i),
    .load_en_o      (load_en_o),
    .load_payload_o (load_payload_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected issue schedule indexed by cycle number since start (cycle 1 = first issue).
  bit sched_v  [T_MAX];
  int sched_hi [T_MAX];
  int sched_lo [T_MAX];
  int t_last, t_done;

  int          mt = 0;          // model cycle index: 0 idle, 1..t_done within a sequence
  logic [31:0] last_pl = '0;
  logic        prev_rd = 1'b0;
  logic [AW-1:0] prev_hi = '0, prev_lo = '0;

  int st_le, st_low, st_gap_ok, st_gap_bad, st_done_n, st_done_cyc;
  bit st_seen;

  // SRAM contents: an injective scramble of the address.
  function automatic logic [15:0] mem(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s cyc=%0d model_t=%0d got=%0h expected=%0h", nm, cyc, mt, act, exp);
    end
  endtask

  task automatic build_sched();
    int t;
    for (int x = 0; x < T_MAX; x++) begin
      sched_v[x] = 1'b0; sched_hi[x] = 0; sched_lo[x] = 0;
    end
    t = 1;
    for (int k = 0; k < 32; k++) begin
      for (int i = 1; i <= 8; i++) begin
        if (k % 2 == 0) begin
          sched_hi[t] = 16 * (k / 2) + 17 - 2 * i;
          sched_lo[t] = 16 * (k / 2) + 16 - 2 * i;
        end else begin
          sched_hi[t] = 256 + 16 * (17 - 2 * i) + (k - 1) / 2;
          sched_lo[t] = 256 + 16 * (16 - 2 * i) + (k - 1) / 2;
        end
        sched_v[t] = 1'b1;
        t++;
      end
    end
    for (int n = 1; n < N_LAYER; n++) begin
      t += GAP;
      for (int k = 0; k < 16; k++) begin
        for (int i = 1; i <= 8; i++) begin
          sched_hi[t] = 256 + 256 * n + 16 * (17 - 2 * i) + (15 - ((k + 2 * i - 2) % 16));
          sched_lo[t] = 256 + 256 * n + 16 * (16 - 2 * i) + (15 - ((k + 2 * i - 1) % 16));
          sched_v[t]  = 1'b1;
          t++;
        end
      end
    end
    t_last = t - 1;
    t_done = t_last + 3;
  endtask

  task automatic stats_clear();
    st_le = 0; st_low = 0; st_gap_ok = 0; st_gap_bad = 0;
    st_done_n = 0; st_done_cyc = 0; st_seen = 1'b0;
  endtask

  // Apply inputs for one cycle, advance the model, then check every output.
  task automatic cycle(input bit s, input bit a, input bit r);
    logic [31:0] exp_pl;
    bit          e_rd, e_le;
    int          e_hi, e_lo;
    start_i = s;
    abort_i = a;
    rst_n   = !r;
    @(posedge clk_data);
    cyc++;
    if (r) begin
      mt = 0; last_pl = '0;
    end else if (mt >= 1 && mt < t_done && a) mt = 0;
    else if ((mt == 0 || mt == t_done) && s) mt = 1;
    else if (mt >= 1 && mt < t_done) mt++;
    else mt = 0;
    #1;
    rd_data_hi_i = prev_rd ? mem(int'(prev_hi)) : 16'($urandom);
    rd_data_lo_i = prev_rd ? mem(int'(prev_lo)) : 16'($urandom);
    e_rd   = sched_v[mt];
    e_hi   = e_rd ? sched_hi[mt] : 0;
    e_lo   = e_rd ? sched_lo[mt] : 0;
    e_le   = (mt >= 3) && sched_v[mt - 2];
    exp_pl = e_le ? {mem(sched_hi[mt - 2]), mem(sched_lo[mt - 2])} : last_pl;
    chk("busy",    32'(busy_o),       32'(mt >= 1 && mt < t_done));
    chk("done",    32'(done_o),       32'(mt == t_done));
    chk("rd_en",   32'(rd_en_o),      32'(e_rd));
    chk("addr_hi", 32'(rd_addr_hi_o), 32'(e_hi));
    chk("addr_lo", 32'(rd_addr_lo_o), 32'(e_lo));
    chk("load_en", 32'(load_en_o),    32'(e_le));
    chk("payload", load_payload_o,    exp_pl);
    last_pl = exp_pl;
    prev_rd = rd_en_o; prev_hi = rd_addr_hi_o; prev_lo = rd_addr_lo_o;
    if (load_en_o) begin
      st_le++;
      if (st_seen && st_low > 0) begin
        if (st_low == GAP) st_gap_ok++;
        else st_gap_bad++;
      end
      st_seen = 1'b1; st_low = 0;
    end else if (st_seen) st_low++;
    if (done_o) begin st_done_n++; st_done_cyc = cyc; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, nv, guard, ab, rs, nidle;
    bit s, a, r;
    build_sched();

    // Pin the model against hand-derived points of the map and timeline.
    nv = 0;
    for (int x = 0; x < T_MAX; x++) nv += int'(sched_v[x]);
    chk("mdl_beats",   32'(nv), 32'd1152);
    chk("mdl_t_last",  32'(t_last), 32'd1320);
    chk("mdl_t_done",  32'(t_done), 32'd1323);
    chk("mdl_b1_hi",   32'(sched_hi[1]), 32'd15);
    chk("mdl_b1_lo",   32'(sched_lo[1]), 32'd14);
    chk("mdl_b8",      32'({sched_hi[8][15:0], sched_lo[8][15:0]}), {16'd1, 16'd0});
    chk("mdl_b9",      32'({sched_hi[9][15:0], sched_lo[9][15:0]}), {16'd496, 16'd480});
    chk("mdl_b17",     32'({sched_hi[17][15:0], sched_lo[17][15:0]}), {16'd31, 16'd30});
    chk("mdl_l1_first", 32'({sched_hi[281][15:0], sched_lo[281][15:0]}), {16'd767, 16'd750});
    chk("mdl_l1_k3b8", 32'({sched_hi[312][15:0], sched_lo[312][15:0]}), {16'd542, 16'd525});
    chk("mdl_l7_start", 32'({sched_v[1192], sched_v[1193]}), 32'b01);
    // Layer 7, k=15, i=8: hi row 1 col 2, lo row 0 col 1 of W7 (base 2048).
    chk("mdl_last",    32'({sched_hi[1320][15:0], sched_lo[1320][15:0]}), {16'd2066, 16'd2049});

    // Reset, then a full run with ignored start pulses at t=10 and t=1322.
    repeat (3) cycle(0, 0, 1);
    cycle(0, 0, 0);
    stats_clear();
    s0 = cyc;
    cycle(1, 0, 0);
    for (int j = 0; j < 1330; j++) cycle(mt == 10 || mt == 1322, 0, 0);
    chk("run_le_count",  32'(st_le), 32'd1152);
    chk("run_gaps24",    32'(st_gap_ok), 32'(N_LAYER - 1));
    chk("run_gaps_bad",  32'(st_gap_bad), 32'd0);
    chk("run_done_n",    32'(st_done_n), 32'd1);
    chk("run_done_cyc",  32'(st_done_cyc - s0), 32'd1323);

    // Abort at issue cycle 500, then a back-to-back restart in the done cycle.
    stats_clear();
    cycle(1, 0, 0);
    guard = 0;
    while (mt != 500 && guard < 2000) begin cycle(0, 0, 0); guard++; end
    cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 0);
    chk("abort_no_done", 32'(st_done_n), 32'd0);
    cycle(1, 0, 0);
    guard = 0;
    while (mt != t_done && guard < 2000) begin cycle(0, 0, 0); guard++; end
    cycle(1, 0, 0);
    chk("restart_busy", 32'(busy_o), 32'd1);
    guard = 0;
    while (mt != 0 && guard < 2000) begin cycle(0, 0, 0); guard++; end

    // Reset mid-sequence, release, full run.
    cycle(1, 0, 0);
    repeat (700) cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (1330) cycle(0, 0, 0);

    // Randomized sequences: stray starts, random abort/reset points, idle noise.
    for (int sq = 0; sq < 6; sq++) begin
      ab = (sq % 2 == 1) ? int'($urandom_range(1, 1322)) : 0;
      rs = (sq == 4) ? int'($urandom_range(1, 1322)) : 0;
      nidle = int'($urandom_range(0, 4));
      for (int j = 0; j < nidle; j++) begin
        a = 1'($urandom_range(0, 1));
        cycle(0, a, 0);
      end
      cycle(1, 0, 0);
      for (int j = 0; j < 1330; j++) begin
        s = ($urandom_range(0, 31) == 0);
        a = (ab != 0 && mt == ab);
        r = (rs != 0 && mt == rs);
        cycle(s, a, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
